// File: rtl/vga_pattern_source.sv
// Active-area pixel pointer plus four run-time selectable test patterns for the VGA controller.
// o_color is registered from the next-state pointer so it always matches o_x/o_y/o_mode.
module vga_pattern_source #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int BOX_SIZE   = 32,
  parameter int BOX_STEP   = 2,
  parameter int CHECK_LOG2 = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sending,
  input  logic        i_frame_start,
  input  logic        i_mode_next,
  input  logic [23:0] i_solid_color,
  output logic [23:0] o_color,
  output logic [9:0]  o_x,
  output logic [9:0]  o_y,
  output logic [1:0]  o_mode,
  output logic        o_frame_done
);

  localparam logic [9:0]  X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_ACTIVE - 1);
  localparam logic [10:0] BSIZE  = 11'(BOX_SIZE);
  localparam logic [10:0] BSTEP  = 11'(BOX_STEP);
  localparam logic [10:0] X_LIM  = 11'(H_ACTIVE);
  localparam logic [10:0] Y_LIM  = 11'(V_ACTIVE);

  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [1:0]  mode_q, mode_d, pend_q, pend_d;
  logic        done_q, done_d, key_q, key_d;
  logic [23:0] color_q, color_d;
  logic [10:0] bx_q, bx_d, by_q, by_d;
  logic        dx_q, dx_d, dy_q, dy_d;
  logic        wrap;

  // One bounce step on a single axis; returns {direction(1 = increasing), position}.
  function automatic logic [11:0] box_move(input logic [10:0] b, input logic dir,
                                           input logic [10:0] limit);
    logic [11:0] r;
    if (dir) begin
      if (b + BSIZE + BSTEP > limit) r = {1'b0, b - BSTEP};
      else                           r = {1'b1, b + BSTEP};
    end else begin
      if (b < BSTEP) r = {1'b1, b + BSTEP};
      else           r = {1'b0, b - BSTEP};
    end
    return r;
  endfunction

  function automatic logic [23:0] bar_color(input logic [9:0] x);
    logic [2:0] idx;
    idx = '0;
    for (int i = 1; i < 8; i++)
      if (int'(x) * 8 >= i * H_ACTIVE) idx = 3'(i);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] pattern(input logic [9:0] x, input logic [9:0] y,
                                          input logic [1:0] mode, input logic [10:0] bx,
                                          input logic [10:0] by, input logic [23:0] solid);
    logic [10:0] x11, y11;
    x11 = {1'b0, x};
    y11 = {1'b0, y};
    case (mode)
      2'd0:    return solid;
      2'd1:    return bar_color(x);
      2'd2:    return (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? 24'h000000 : 24'hFFFFFF;
      default: return (x11 >= bx && x11 < bx + BSIZE && y11 >= by && y11 < by + BSIZE)
                      ? 24'hFFFFFF : 24'h0000FF;
    endcase
  endfunction

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    mode_d = mode_q;
    bx_d   = bx_q;
    by_d   = by_q;
    dx_d   = dx_q;
    dy_d   = dy_q;
    wrap   = 1'b0;
    key_d  = i_mode_next;
    pend_d = (i_mode_next && !key_q) ? pend_q + 2'd1 : pend_q;

    // Resync wins over a consume in the same cycle and never counts as a frame wrap.
    if (i_frame_start) begin
      x_d    = '0;
      y_d    = '0;
      mode_d = pend_q;
    end else if (i_sending) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d  = '0;
          wrap = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    if (wrap) begin
      mode_d       = pend_q;
      {dx_d, bx_d} = box_move(bx_q, dx_q, X_LIM);
      {dy_d, by_d} = box_move(by_q, dy_q, Y_LIM);
    end

    done_d  = wrap;
    color_d = pattern(x_d, y_d, mode_d, bx_d, by_d, i_solid_color);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      mode_q  <= '0;
      pend_q  <= '0;
      done_q  <= 1'b0;
      key_q   <= 1'b0;
      color_q <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      key_q   <= key_d;
      color_q <= color_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
    end
  end

  assign o_color      = color_q;
  assign o_x          = x_q;
  assign o_y          = y_q;
  assign o_mode       = mode_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_vga_pattern_source.sv
// Directed bench for vga_pattern_source on a reduced 32x24 raster (box 8, step 2, checker 4 px)
// so that many frame wraps and full box bounces fit in a short run.
module tb_vga_pattern_source;

  localparam int H = 32;
  localparam int V = 24;
  localparam int B = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sending = 1'b0;
  logic        fs = 1'b0;
  logic        mn = 1'b0;
  logic [23:0] solid = 24'h123456;
  logic [23:0] o_color;
  logic [9:0]  o_x, o_y;
  logic [1:0]  o_mode;
  logic        o_frame_done;

  int nvec = 0;
  int nerr = 0;
  int ex = 0, ey = 0, nw = 0;
  logic [1:0] emode = 2'd0;
  logic [1:0] epend = 2'd0;

  // Box position after k frame wraps from reset, worked out by hand for a 32x24 area.
  int bx_tab [18] = '{0, 2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 22, 24, 22, 20, 18, 16, 14};
  int by_tab [18] = '{0, 2, 4, 6, 8, 10, 12, 14, 16, 14, 12, 10, 8, 6, 4, 2, 0, 2};
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  vga_pattern_source #(
    .H_ACTIVE(H), .V_ACTIVE(V), .BOX_SIZE(B), .BOX_STEP(2), .CHECK_LOG2(2)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_sending(sending),
    .i_frame_start(fs),
    .i_mode_next(mn),
    .i_solid_color(solid),
    .o_color(o_color),
    .o_x(o_x),
    .o_y(o_y),
    .o_mode(o_mode),
    .o_frame_done(o_frame_done)
  );

  always #20 clk = ~clk;

  function automatic logic [23:0] exp_color(input int x, input int y);
    int bx, by;
    bx = bx_tab[nw];
    by = by_tab[nw];
    case (emode)
      2'd0:    return solid;
      2'd1:    return bars[(x * 8) / H];
      2'd2:    return ((((x >> 2) ^ (y >> 2)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
      default: return (x >= bx && x < bx + B && y >= by && y < by + B) ? 24'hFFFFFF : 24'h0000FF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s at (%0d,%0d): observed %h expected %h", tag, ex, ey, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input logic exp_done);
    check("x", 32'(o_x), ex);
    check("y", 32'(o_y), ey);
    check("frame_done", 32'(o_frame_done), 32'(exp_done));
    check("mode", 32'(o_mode), 32'(emode));
    check("color", 32'(o_color), 32'(exp_color(ex, ey)));
  endtask

  task automatic send(input int n);
    logic wrapped;
    sending = 1'b1;
    repeat (n) begin
      step();
      wrapped = 1'b0;
      if (ex == H - 1) begin
        ex = 0;
        if (ey == V - 1) begin
          ey = 0;
          wrapped = 1'b1;
          nw++;
          emode = epend;
        end else begin
          ey++;
        end
      end else begin
        ex++;
      end
      check_all(wrapped);
    end
    sending = 1'b0;
  endtask

  task automatic key_pulse();
    mn = 1'b1;
    step();
    mn = 1'b0;
    step();
    epend = epend + 2'd1;
    check_all(1'b0);
  endtask

  task automatic resync();
    sending = 1'b1;
    fs = 1'b1;
    step();
    fs = 1'b0;
    sending = 1'b0;
    ex = 0;
    ey = 0;
    emode = epend;
    check_all(1'b0);
  endtask

  initial begin
    #5 rst_n = 1'b0;
    #2;
    check("reset_color_async", 32'(o_color), 32'h0);
    check("reset_x", 32'(o_x), 0);
    repeat (2) step();
    check("reset_color_clocked", 32'(o_color), 32'h0);
    check("reset_done", 32'(o_frame_done), 0);
    rst_n = 1'b1;
    step();
    check("first_color", 32'(o_color), 32'h123456);
    check_all(1'b0);

    // Pointer holds while nothing is consumed.
    repeat (3) begin
      step();
      check_all(1'b0);
    end
    solid = 24'hABCDEF;
    step();
    check("solid_follow", 32'(o_color), 32'hABCDEF);

    // Mode request mid-frame only takes effect at the wrap.
    send(100);
    key_pulse();
    check("mode_held", 32'(o_mode), 0);
    send(H * V - 100);
    check("wrap_mode1", 32'(o_mode), 1);
    check("wrap_bar0", 32'(o_color), 32'hFFFFFF);
    send(H);

    // Checkerboard across a whole frame.
    key_pulse();
    send(H * V - H);
    check("mode2", 32'(o_mode), 2);
    send(H * V);

    // Resync mid-frame at (10,5) together with a consume.
    key_pulse();
    send(5 * H + 10);
    check("pre_resync_x", 32'(o_x), 10);
    resync();
    check("resync_mode3", 32'(o_mode), 3);
    check("resync_nodone", 32'(o_frame_done), 0);

    // Bouncing box through both reversals on each axis.
    send(H * V * 14);
    check("wrap_count", nw, 17);

    // Asynchronous reset mid-frame with the box at (14,2).
    send(5 * H + 9);
    #5 rst_n = 1'b0;
    #1;
    check("arst_x", 32'(o_x), 0);
    check("arst_y", 32'(o_y), 0);
    check("arst_mode", 32'(o_mode), 0);
    check("arst_color", 32'(o_color), 32'h0);
    check("arst_done", 32'(o_frame_done), 0);
    ex = 0;
    ey = 0;
    nw = 0;
    emode = 2'd0;
    epend = 2'd0;
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_color", 32'(o_color), 32'hABCDEF);

    // Box position and pending mode were cleared by that reset.
    key_pulse();
    key_pulse();
    key_pulse();
    resync();
    check("box_home", 32'(o_color), 32'hFFFFFF);
    send(9 * H);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/vga_pattern_source.md
Name: vga_pattern_source

Overview:
Upstream pixel source for the VGA controller. It tracks the active-area pixel pointer from the controller's per-pixel consume strobe and presents the 24-bit RGB colour for that pixel. The colour comes from one of four built-in test patterns, which are selectable at run time by a key pulse. It runs on the 25 MHz pixel clock and replaces the fixed-colour key logic in the top level.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
BOX_SIZE, 32, side length of the moving box in pixels
BOX_STEP, 2, box displacement per frame on each axis, in pixels
CHECK_LOG2, 5, checker square size is 2^CHECK_LOG2 pixels

Ports:
i_clk  in  1  pixel clock (25 MHz domain)
i_rst_n  in  1  asynchronous reset, active-low
i_sending  in  1  controller consumes o_color this cycle (high only in active area)
i_frame_start  in  1  one-cycle resync pulse at vertical sync
i_mode_next  in  1  level key input; each rising edge requests the next pattern
i_solid_color  in  24  {R,G,B} colour used by mode 0
o_color  out  24  {R,G,B} colour for pixel (o_x, o_y)
o_x  out  10  current column, 0..H_ACTIVE-1
o_y  out  10  current line, 0..V_ACTIVE-1
o_mode  out  2  active pattern
o_frame_done  out  1  one-cycle pulse after the last pixel of a frame is consumed

Behaviour:
- Clock and reset: one clock, i_clk. i_rst_n is asynchronous and active-low. All state is reset by i_rst_n.
- Reset values: o_x=0, o_y=0, o_mode=0, pending mode=0, o_frame_done=0, o_color=24'h0, box position (0,0), box direction +x,+y, key edge register=0.
- Pointer advance: on a cycle with i_sending=1, x increments.
  - At x=H_ACTIVE-1, x wraps to 0 and y increments.
  - At (H_ACTIVE-1, V_ACTIVE-1), the pointer wraps to (0,0) and the frame-wrap event fires.
  - With i_sending=0 the pointer holds.
- Resync: i_frame_start=1 forces the pointer to (0,0).
  - It takes priority over i_sending in the same cycle; there is no advance and no frame-wrap event.
  - At resync the pending mode is applied to o_mode. Box position is not changed.
- Frame wrap:
  - o_frame_done=1 on the following cycle, for exactly one cycle.
  - Pending mode is copied into o_mode in the same edge.
  - The box moves one step.
- Mode request: a rising edge on i_mode_next (registered previous value, compare) sets pending = pending+1 mod 4.
  - o_mode changes only at a frame wrap or resync, so there is no mid-frame tearing.
  - Multiple edges within one frame accumulate.
- Colour path:
  - o_color is a register loaded every cycle with colour(x_next, y_next, mode_next, box_next), so o_color always matches o_x/o_y/o_mode in the same cycle.
  - Zero-cycle pointer-to-colour latency as seen by the consumer.
  - First cycle after reset release: colour of (0,0), mode 0 = i_solid_color.
- Patterns:
  - Mode 0: i_solid_color, sampled through the same next-state path.
  - Mode 1: eight vertical bars, bar index = x*8/H_ACTIVE (integer; 80 px each at 640). Bar colours in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Mode 2: checkerboard, FFFFFF when x[CHECK_LOG2]^y[CHECK_LOG2]=0, else 000000.
  - Mode 3: FFFFFF if bx<=x<bx+BOX_SIZE and by<=y<by+BOX_SIZE, else background 0000FF.
- Box motion per axis at frame wrap:
  - Direction +: if b+BOX_SIZE+BOX_STEP > limit, reverse and move b-BOX_STEP; otherwise b+BOX_STEP.
  - Direction −: if b < BOX_STEP, reverse and move b+BOX_STEP; otherwise b-BOX_STEP.
  - Box never leaves [0, limit-BOX_SIZE].
  - Arithmetic uses 11-bit unsigned to avoid overflow.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). o_color goes to 0 until the first clock after release.

Test Plan:
- Reset, i_solid_color=24'h123456, mode 0, hold i_sending=0 -> o_color=24'h000000 during reset, 24'h123456 one cycle after release; o_x=o_y=0; o_frame_done stays 0.
- Pulse i_mode_next once mid-frame, then stream 640*480 i_sending cycles -> o_mode stays 0 until the wrap edge, then becomes 1. o_frame_done pulses once. After wrap, o_color=FFFFFF at x=0, FFFF00 at x=80, 000000 at x=639.
- Mode 2, stream one line -> o_color toggles between FFFFFF and 000000 every 32 pixels. Line y=32 starts with 000000.
- Mode 3, run 320 frames -> bx follows 0,2,…,608 then reverses to 606 (dir −); by reverses after reaching 448; box pixels are FFFFFF, all others 0000FF.
- i_frame_start and i_sending high together at (100,50) -> pointer (0,0) next cycle, no o_frame_done, box unchanged, pending mode applied.
- Assert i_rst_n=0 at (300,200) in mode 3 with the box at (40,40) -> o_x=o_y=0, o_mode=0, box (0,0), o_color=0 immediately, without waiting for a clock edge.
